// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: chunk sizing for the pipelined decoder and
// word-level reference conversions.
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Ceiling division; a zero stage count is rejected by the decoder itself.
  function automatic int gray_chunk_size(int width, int stages);
    if (stages < 1) return width;
    return (width + stages - 1) / stages;
  endfunction

  function automatic gray_word_t bin2gray(gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_decoder_stage.sv
// One pipeline stage of the Gray decoder: converts bits HI..LO of the word in
// place (bits above are already binary) and registers the result.
module gray_decoder_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int HI         = 7,
  parameter int LO         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] conv;

  // The MSB of the word is identical in both codes, so the chain starts one
  // below it; an empty range (LO > HI) leaves the vector untouched.
  always_comb begin
    conv = up_data;
    for (int i = DATA_WIDTH-2; i >= 0; i--) begin
      if (i <= HI && i >= LO) conv[i] = conv[i+1] ^ up_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= up_valid;
      if (up_valid) data <= conv;
    end
  end

endmodule

// File: rtl/gray_decoder_pipe.sv
// Streaming Gray-to-binary decoder with the prefix-XOR chain split across
// NUM_STAGES registered stages and a valid/ready handshake on both sides.
module gray_decoder_pipe
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_gray,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_bin,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int CHUNK = gray_chunk_size(DATA_WIDTH, NUM_STAGES);

  if (DATA_WIDTH < 1 || NUM_STAGES < 1 || NUM_STAGES > DATA_WIDTH) begin : g_bad_params
    $error("gray_decoder_pipe: need DATA_WIDTH >= 1 and NUM_STAGES in 1..DATA_WIDTH");
  end

  logic [NUM_STAGES-1:0]                 valid_q;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] data_q;
  logic [NUM_STAGES-1:0]                 en;

  // Ready ripples back from the sink; an empty stage always accepts, which
  // is what lets bubbles collapse under backpressure.
  always_comb begin
    logic nxt;
    en  = '0;
    nxt = i_ready;
    for (int s = NUM_STAGES-1; s >= 0; s--) begin
      en[s] = !valid_q[s] || nxt;
      nxt   = en[s];
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int HI     = DATA_WIDTH - 1 - s*CHUNK;
    localparam int LO_RAW = DATA_WIDTH - (s+1)*CHUNK;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    logic                  up_valid;
    logic [DATA_WIDTH-1:0] up_data;

    if (s == 0) begin : g_src_in
      assign up_valid = i_valid;
      assign up_data  = i_gray;
    end else begin : g_src_prev
      assign up_valid = valid_q[s-1];
      assign up_data  = data_q[s-1];
    end

    gray_decoder_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .HI        (HI),
      .LO        (LO)
    ) u_stage (
      .clk     (i_clk),
      .rst     (i_rst),
      .en      (en[s]),
      .up_valid(up_valid),
      .up_data (up_data),
      .valid   (valid_q[s]),
      .data    (data_q[s])
    );
  end

  assign o_ready = en[0];
  assign o_valid = valid_q[NUM_STAGES-1];
  assign o_bin   = data_q[NUM_STAGES-1];

endmodule

// File: tb/tb_gray_decoder_pipe.sv
// Bench for gray_decoder_pipe: several configurations side by side, each with
// its own scoreboard queue fed at input transfer and drained at output transfer.
module tb_gray_decoder_pipe;
  import gray_pkg::*;

  localparam int NCFG = 7;
  localparam int WS [NCFG] = '{8, 8, 8, 8, 13, 1, 5};
  localparam int SS [NCFG] = '{1, 2, 3, 8, 4,  1, 5};

  logic              clk;
  logic              rst;
  logic [63:0]       gin;
  logic [NCFG-1:0]   vin;
  logic [NCFG-1:0]   rin;
  logic [NCFG-1:0]   ov;
  logic [NCFG-1:0]   ordy;
  logic [63:0]       ob [NCFG];
  int                pend [NCFG];
  int                n_chk;
  int                n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int W = WS[k];
    localparam int S = SS[k];

    logic [W-1:0] bin;
    logic         vld;
    logic         rdy;

    gray_decoder_pipe #(.DATA_WIDTH(W), .NUM_STAGES(S)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_gray (gin[W-1:0]),
      .i_valid(vin[k]),
      .o_ready(rdy),
      .o_bin  (bin),
      .o_valid(vld),
      .i_ready(rin[k])
    );

    assign ov[k]   = vld;
    assign ordy[k] = rdy;
    assign ob[k]   = 64'(bin);

    logic [63:0] q [$];
    logic [63:0] hold_bin;
    logic        hold_chk = 1'b0;
    logic [63:0] exp_bin;

    // Inputs are stable from the last posedge+1 to the next posedge, so the
    // handshake seen here is exactly what the coming edge will act on.
    always @(negedge clk) begin
      if (hold_chk) begin
        n_chk++;
        assert (ov[k] === 1'b1 && ob[k] === hold_bin) else begin
          n_fail++;
          $error("FAIL hold[%0d]: observed valid=%0b bin=%0h expected valid=1 bin=%0h",
                 k, ov[k], ob[k], hold_bin);
        end
      end
      hold_chk = ov[k] && !rin[k] && !rst;
      hold_bin = ob[k];
      if (rst) begin
        q.delete();
      end else begin
        if (ov[k] && rin[k]) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $error("FAIL spurious[%0d]: observed output %0h expected no output", k, ob[k]);
          end else begin
            exp_bin = q.pop_front();
            assert (ob[k] === exp_bin) else begin
              n_fail++;
              $error("FAIL stream[%0d]: observed %0h expected %0h", k, ob[k], exp_bin);
            end
          end
        end
        if (vin[k] && ordy[k]) q.push_back(gray2bin(64'(gin[W-1:0])));
      end
      pend[k] = q.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word to config k and count edges until it reaches the output.
  task automatic lat_test(int k, logic [63:0] g, int lat, logic [63:0] expb);
    int c;
    gin    = g;
    vin[k] = 1'b1;
    rin[k] = 1'b1;
    @(negedge clk);
    check("lat_ready", 64'(ordy[k]), 64'd1);
    tick();
    vin[k] = 1'b0;
    c = 1;
    while (!ov[k] && c < 64) begin
      tick();
      c++;
    end
    check("latency", 64'(c), 64'(lat));
    check("lat_bin", ob[k], expb);
    tick();
  endtask

  initial begin
    int sent;
    int cyc;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    vin    = '0;
    rin    = '1;
    gin    = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Post-reset state on every configuration.
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      check("rst_valid", 64'(ov[k]), 64'd0);
      check("rst_bin",   ob[k],       64'd0);
      check("rst_ready", 64'(ordy[k]), 64'd1);
    end
    tick();

    // Single words, W=8 S=2.
    lat_test(1, 64'hC0, 2, 64'h80);
    lat_test(1, 64'h80, 2, 64'hFF);

    // Exhaustive back-to-back stream into all W=8 configs at once.
    for (int t = 0; t < 264; t++) begin
      gin      = bin2gray(64'(t & 255));
      vin[3:0] = (t < 256) ? 4'hF : 4'h0;
      tick();
      for (int k = 0; k < 4; k++)
        check($sformatf("stream_valid[%0d]@%0d", k, t), 64'(ov[k]),
              64'(((t+1) >= SS[k]) && ((t+1) < SS[k] + 256)));
    end
    vin = '0;
    repeat (4) tick();

    // Backpressure, W=8 S=2.
    rin[1] = 1'b0;
    vin[1] = 1'b1;
    gin    = 64'h01;
    @(negedge clk); check("bp_acc0", 64'(ordy[1]), 64'd1);
    tick();
    gin = 64'h03;
    @(negedge clk); check("bp_acc1", 64'(ordy[1]), 64'd1);
    tick();
    gin = 64'h02;
    @(negedge clk);
    check("bp_full",  64'(ordy[1]), 64'd0);
    check("bp_valid", 64'(ov[1]),   64'd1);
    check("bp_bin",   ob[1],        64'h01);
    tick();
    @(negedge clk);
    check("bp_full2", 64'(ordy[1]), 64'd0);
    check("bp_bin2",  ob[1],        64'h01);
    tick();
    rin[1] = 1'b1;
    @(negedge clk); check("bp_release", 64'(ordy[1]), 64'd1);
    tick();
    vin[1] = 1'b0;
    repeat (4) tick();

    // Random valid/ready toggling, W=13 S=4.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 50000) begin
      gin    = 64'($urandom) & 64'h1FFF;
      vin[4] = 1'($urandom_range(1, 0));
      rin[4] = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (vin[4] && ordy[4]) sent++;
      tick();
      cyc++;
    end
    check("rand_sent", 64'(sent), 64'd10000);
    vin[4] = 1'b0;
    rin[4] = 1'b1;
    repeat (8) tick();

    // Reset with three words in flight, W=8 S=3.
    rin[2] = 1'b1;
    vin[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gin = bin2gray(64'(i + 5));
      tick();
    end
    gin = 64'hAA;
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    vin[2] = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(ov[2]),   64'd0);
    check("mid_rst_bin",   ob[2],        64'd0);
    check("mid_rst_ready", 64'(ordy[2]), 64'd1);
    repeat (5) begin
      tick();
      check("mid_rst_stale", 64'(ov[2]), 64'd0);
    end
    lat_test(2, 64'h5A, 3, 64'h6C);

    // Width edge cases.
    lat_test(5, 64'h1,  1, 64'h1);
    lat_test(6, 64'h1F, 5, 64'h15);

    repeat (12) tick();
    for (int k = 0; k < NCFG; k++) check($sformatf("drained[%0d]", k), 64'(pend[k]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_decoder_pipe.md
Name: gray_decoder_pipe

Overview:
- Streaming Gray-to-binary decoder; converts the Gray code produced by the library's Gray encoder back to binary.
- The MSB-first prefix-XOR chain is split across NUM_STAGES register stages for timing closure on wide words.
- Valid/ready handshake on both sides, full throughput of one word per cycle.
- Sits in the coders library, e.g. on the read side of CDC pointer paths and in position-sensor front ends.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be >= 1.
- NUM_STAGES, 2, number of pipeline register stages; must be in 1..DATA_WIDTH, elaboration error otherwise.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_gray  input  DATA_WIDTH  Gray-coded input word.
- i_valid  input  1  i_gray is valid.
- o_ready  output  1  block accepts i_gray this cycle.
- o_bin  output  DATA_WIDTH  decoded binary word.
- o_valid  output  1  o_bin is valid.
- i_ready  input  1  downstream accepts o_bin this cycle.

Behaviour:
- Decode function: bin[W-1] = gray[W-1]; bin[i] = bin[i+1] ^ gray[i] for i = W-2 down to 0. W is DATA_WIDTH.
- Chunking:
  - C = ceil(W/NUM_STAGES).
  - Stage s (0-based, s = 0 is input side) converts bits W-1-s*C down to max(W-(s+1)*C, 0) in place.
  - Each stage holds one W-bit vector: bits above the current chunk are already binary, bits below are still Gray.
  - A stage whose range is empty, which can happen when C*NUM_STAGES > W, passes the vector through unchanged but still registers it.
- Pipeline registers: each stage has valid_q[s] and data_q[s]. o_valid = valid_q[NUM_STAGES-1] and o_bin = data_q[NUM_STAGES-1].
- Handshake:
  - Per-stage advance enable: en[s] = !valid_q[s] || en_next. en_next is en[s+1], or i_ready for the last stage.
  - o_ready = en[0]. It is combinational from i_ready (no skid buffer), and there is no combinational path from i_valid to o_ready.
  - Transfer in on i_valid && o_ready; transfer out on o_valid && i_ready.
  - When en[s] = 1, stage s loads from its upstream: valid and data from stage s-1, or from i_valid and i_gray for stage 0.
- Latency: exactly NUM_STAGES cycles from input transfer to o_valid when there is no backpressure.
- Throughput: 1 word/cycle sustained while i_ready = 1.
- Backpressure:
  - While o_valid && !i_ready, o_bin and o_valid hold stable.
  - Bubbles collapse: an empty stage accepts even when the stage below is stalled.
  - Capacity is NUM_STAGES words. o_ready falls only when every stage is full and i_ready = 0.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Reset:
  - While i_rst = 1 at a clock edge, all valid_q and data_q clear to 0.
  - The cycle after reset: o_valid = 0, o_bin = 0, o_ready = 1.
  - Reset mid-stream discards all in-flight words. An input offered during the reset cycle is not captured.
- DATA_WIDTH = 1: o_bin = i_gray delayed by NUM_STAGES (which must be 1).
- No X propagation: data_q is reset even though only the valid bits are functionally required.

Decomposition:
- Package gray_pkg:
  - Function gray_chunk_size(width, stages) returning ceil division.
  - Reference functions bin2gray and gray2bin, shared by RTL assertions and the testbench.
- Sub-module gray_decoder_stage:
  - Parameters DATA_WIDTH, HI, LO (LO > HI denotes an empty range).
  - Contains one register stage plus its valid/enable logic.
  - Instantiated NUM_STAGES times in a generate loop by gray_decoder_pipe.

Test Plan:
- Single word, W=8, S=2, i_ready=1: i_gray=8'hC0 -> o_bin=8'h80 with o_valid high exactly 2 cycles after the transfer. Then i_gray=8'h80 -> 8'hFF.
- Exhaustive streaming, W=8, S in {1,2,3,8}: bin2gray(0..255) presented back to back -> outputs 0..255 in order. Latency S, one output per cycle, no gaps.
- Backpressure, W=8, S=2: i_ready=0 while offering 3 words (gray 8'h01, 8'h03, 8'h02):
  - Two words are accepted and o_ready=0 on the third.
  - o_bin holds 8'h01 stable.
  - After i_ready=1, outputs are 8'h01, 8'h02, 8'h03 in order, and the third word is accepted.
- Random i_valid/i_ready toggling (50%), 10k words, W=13, S=4 (uneven chunks, C=4): output stream equals gray2bin of the input stream; o_bin never changes while o_valid && !i_ready.
- Reset mid-stream, W=8, S=3: i_rst=1 for one cycle with 3 words in flight -> next cycle o_valid=0, o_bin=0, o_ready=1. No stale words emerge afterwards; the first post-reset word appears 3 cycles after its transfer.
- Width edge cases: W=1, S=1: i_gray=1 -> o_bin=1 after 1 cycle. W=5, S=5: i_gray=5'b11111 -> o_bin=5'b10101 after 5 cycles.
